// File: rtl/nixie_text_scroller_pkg.sv
// -----------------------------------------------------------------------------
// nixie_text_scroller_pkg
// Character codes shared by the nixie/7-seg display driver and the text
// scroller, plus window geometry, scroller state codes and a length clamp.
// No ports (package).
// -----------------------------------------------------------------------------
package nixie_text_scroller_pkg;

    // Geometry of the character bus and the message buffer
    localparam int CHAR_W    = 6;
    localparam int NUM_SLOTS = 8;
    localparam int BUF_DEPTH = 16;
    localparam int MAX_LEN   = 16;

    // Character encoding understood by the display driver
    localparam logic [CHAR_W-1:0] CODE_DIGIT_BASE  = 6'd0;   // '0'..'9' -> 0..9
    localparam logic [CHAR_W-1:0] CODE_LETTER_BASE = 6'd10;  // 'A'..'Z' -> 10..35
    localparam logic [CHAR_W-1:0] CODE_DASH        = 6'd36;
    localparam logic [CHAR_W-1:0] CODE_UNDERSCORE  = 6'd37;
    localparam logic [CHAR_W-1:0] CODE_BLANK       = 6'd63;  // all segments off

    // Buffer character 0 lands on the leftmost slot; slot 7 occupies [47:42]
    localparam int SLOT_LEFTMOST = NUM_SLOTS - 1;

    // Scroller states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHOW   = 2'd1;
    localparam logic [1:0] ST_SCROLL = 2'd2;

    // Lengths above the buffer depth are treated as a full buffer
    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return (len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/nixie_step_divider.sv
// -----------------------------------------------------------------------------
// nixie_step_divider
// Free-running tick generator: counts 0..STEP_CYCLES-1 and produces a one-cycle
// step pulse while the count sits at STEP_CYCLES-1. A clear restarts the count
// from 0 on the next edge and suppresses the pulse in that cycle.
// Ports:
//   sys_clk   in   system clock
//   sys_rest  in   synchronous active-low reset
//   i_clear   in   restart the count
//   o_step    out  one-cycle step pulse
// -----------------------------------------------------------------------------
module nixie_step_divider #(
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic sys_clk,
    input  logic sys_rest,
    input  logic i_clear,
    output logic o_step
);

    localparam int CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge sys_clk) begin
        if (!sys_rest) begin
            r_count <= '0;
        end else if (i_clear || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_step = (r_count == LAST) && !i_clear;

endmodule

// File: rtl/nixie_text_scroller.sv
// -----------------------------------------------------------------------------
// nixie_text_scroller
// Holds a 16-entry message buffer and presents an 8-character window to the
// display driver. Short messages (or scroll disabled) are shown left-aligned;
// longer ones scroll left as a marquee with GAP blanks before the restart.
// Ports:
//   sys_clk     in   system clock
//   sys_rest    in   synchronous active-low reset
//   wr_en       in   buffer write strobe
//   wr_addr     in   buffer index 0..15
//   wr_char     in   character code
//   msg_len     in   message length (clamped to 16), sampled on start
//   scroll_en   in   scroll enable, sampled on start
//   start       in   begin/restart display pulse
//   stop        in   blank and go idle pulse (wins over start)
//   disp_data   out  packed window, [47:42] = slot 7 (leftmost)
//   busy        out  high in SHOW or SCROLL
//   wrap_pulse  out  one-cycle pulse when the scroll offset wraps to 0
// -----------------------------------------------------------------------------
module nixie_text_scroller
    import nixie_text_scroller_pkg::*;
#(
    parameter int          STEP_CYCLES = 25_000_000,
    parameter int          GAP         = 2,
    parameter logic [5:0]  BLANK_CODE  = CODE_BLANK
) (
    input  logic        sys_clk,
    input  logic        sys_rest,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [5:0]  wr_char,
    input  logic [4:0]  msg_len,
    input  logic        scroll_en,
    input  logic        start,
    input  logic        stop,
    output logic [47:0] disp_data,
    output logic        busy,
    output logic        wrap_pulse
);

    logic [5:0]  r_buf [BUF_DEPTH];
    logic [1:0]  r_state;
    logic [4:0]  r_len;
    logic [4:0]  r_offset;
    logic [47:0] r_disp;
    logic        r_wrap_pend;   // offset wrapped on the previous edge
    logic        r_wrap;

    logic [4:0]  w_len_c;
    logic        w_start_ok;
    logic        w_step;
    logic [5:0]  w_period;
    logic [5:0]  w_slot [NUM_SLOTS];
    logic [47:0] w_window;

    assign w_len_c    = clamp_len(msg_len);
    assign w_start_ok = start && (w_len_c != 5'd0);
    assign w_period   = {1'b0, r_len} + 6'(GAP);

    nixie_step_divider #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_divider (
        .sys_clk  (sys_clk),
        .sys_rest (sys_rest),
        .i_clear  (w_start_ok || stop),
        .o_step   (w_step)
    );

    // Window mux: slot (7-gi) shows virtual character (offset+gi) mod P.
    // offset <= P-1 and gi <= 7 < P, so one conditional subtract suffices.
    // In SHOW the offset is 0 and the index is used unwrapped, so positions
    // past the message stay blank rather than folding back onto buf[0].
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic [5:0] w_sum;
            logic [5:0] w_idx;
            assign w_sum = {1'b0, r_offset} + 6'(gi);
            assign w_idx = ((r_state == ST_SCROLL) && (w_sum >= w_period))
                           ? (w_sum - w_period) : w_sum;
            assign w_slot[gi] = (w_idx < {1'b0, r_len}) ? r_buf[w_idx[3:0]]
                                                         : BLANK_CODE;
        end
    endgenerate

    always_comb begin
        w_window = {NUM_SLOTS{BLANK_CODE}};
        if (r_state != ST_IDLE) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                w_window[(SLOT_LEFTMOST - i)*CHAR_W +: CHAR_W] = w_slot[i];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rest) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= BLANK_CODE;
            end
            r_state     <= ST_IDLE;
            r_len       <= 5'd0;
            r_offset    <= 5'd0;
            r_disp      <= {NUM_SLOTS{BLANK_CODE}};
            r_wrap_pend <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            if (wr_en) begin
                r_buf[wr_addr] <= wr_char;
            end

            if (stop) begin
                r_state     <= ST_IDLE;
                r_offset    <= 5'd0;
                r_disp      <= {NUM_SLOTS{BLANK_CODE}};
                r_wrap_pend <= 1'b0;
                r_wrap      <= 1'b0;
            end else begin
                r_disp <= w_window;
                // Reported one edge after the offset wrap, alongside the
                // disp_data update that shows offset 0.
                r_wrap <= r_wrap_pend;
                if (w_start_ok) begin
                    r_len       <= w_len_c;
                    r_offset    <= 5'd0;
                    r_wrap_pend <= 1'b0;
                    r_state     <= (scroll_en && (w_len_c > 5'd8)) ? ST_SCROLL
                                                                   : ST_SHOW;
                end else if ((r_state == ST_SCROLL) && w_step) begin
                    if ({1'b0, r_offset} == (w_period - 6'd1)) begin
                        r_offset    <= 5'd0;
                        r_wrap_pend <= 1'b1;
                    end else begin
                        r_offset    <= r_offset + 5'd1;
                        r_wrap_pend <= 1'b0;
                    end
                end else begin
                    r_wrap_pend <= 1'b0;
                end
            end
        end
    end

    assign disp_data  = r_disp;
    assign busy       = (r_state != ST_IDLE);
    assign wrap_pulse = r_wrap;

endmodule

// File: doc/nixie_text_scroller.md
Name: nixie_text_scroller

Overview:
- Upstream feeder for the 8-digit nixie/7-seg display driver.
- Holds a message buffer of up to 16 six-bit character codes, written by the UART/menu logic.
- Presents an 8-character window as the packed 48-bit character bus the driver consumes.
- Messages of 8 characters or fewer are shown static and left-aligned; longer messages scroll left as a marquee with a blank gap, at a programmable step rate.

Parameters:
- STEP_CYCLES, 25_000_000: sys_clk cycles per scroll step (0.25 s at 100 MHz); must be >= 2.
- GAP, 2: blank characters inserted between the end of the message and its restart in scroll mode (0..7).
- BLANK_CODE, 6'd63: character code driven for empty positions; must decode to all segments off.

Ports:
- sys_clk  in  1  system clock, single clock domain.
- sys_rest  in  1  reset, synchronous, active-low.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  4  buffer index 0..15.
- wr_char  in  6  character code, shared encoding with the display driver.
- msg_len  in  5  message length, sampled on start; values >16 are clamped to 16.
- scroll_en  in  1  sampled on start; 1 enables scrolling when the latched length is >8.
- start  in  1  single-cycle pulse: begin or restart display.
- stop  in  1  single-cycle pulse: blank the display and go idle.
- disp_data  out  48  packed window; [47:42] is slot 7 (leftmost), [5:0] is slot 0 (rightmost).
- busy  out  1  high while in SHOW or SCROLL.
- wrap_pulse  out  1  one-cycle pulse each time the scroll offset wraps to 0.

Behaviour:
- Reset (sys_rest=0 at a sys_clk edge):
  - state IDLE; all 16 buffer entries = BLANK_CODE.
  - disp_data = {8{BLANK_CODE}}; busy=0; wrap_pulse=0; offset=0; divider=0.
- Buffer writes:
  - Accepted in any state. buf[wr_addr] <= wr_char on the edge where wr_en=1.
  - A write to a visible position appears on disp_data 2 edges later (write edge, then output register).
- States:
  - IDLE: disp_data holds all blanks.
  - start with clamped length Lc: if Lc==0, start is ignored. Otherwise latch Lc and scroll_en; offset <= 0; divider <= 0; go to SCROLL if (scroll_en && Lc>8), else go to SHOW.
  - SHOW: offset fixed at 0. Slot (7-i) = buf[i] for i<Lc, else BLANK_CODE.
  - SCROLL: period P = Lc+GAP. The virtual string is v[j] = buf[j] for j<Lc, else BLANK_CODE.
    - Slot (7-i) = v[(offset+i) mod P].
    - Width rule: offset+i < 2P, so the mod is a single conditional subtract; no divider.
  - Scroll step: divider counts 0..STEP_CYCLES-1. On reaching STEP_CYCLES-1, divider <= 0 and offset <= (offset==P-1) ? 0 : offset+1.
  - wrap_pulse is asserted in the same cycle as the registered offset=0 transition, i.e. together with the disp_data update one cycle later.
- start while busy: restart from the same edge; re-latch length and mode; offset=0; divider=0.
- stop: state <= IDLE, busy <= 0, disp_data blank on the next edge. stop and start on the same edge: stop wins.
- msg_len and scroll_en changes are ignored except on start.
- disp_data is fully registered, with 1 cycle latency from offset/state/buffer change. Asynchronous to the driver's refresh; no handshake.
- busy is 1 in SHOW and SCROLL. wrap_pulse is never asserted in SHOW.

Decomposition:
- Shared character-code header (existing): letter, digit and symbol codes, plus BLANK_CODE default and the slot-ordering constant, so the driver and the scroller agree.
- One sub-module, nixie_step_divider: enable-free tick generator parameterised by STEP_CYCLES that outputs a one-cycle step pulse and clears on restart.
- Window mux and state machine stay in the top module.

Test Plan:
- Reset check: hold sys_rest=0 for 3 edges -> disp_data=48'hFFFF_FFFF_FFFF, busy=0, wrap_pulse=0. Assert reset mid-scroll -> same values on the next edge.
- Static display:
  - Stimulus: write H,E,L,L,O codes to addr 0..4; msg_len=5; scroll_en=1; start.
  - Response: slots 7..3 = H E L L O, slots 2..0 = blank; offset never moves over 100 cycles; busy=1.
- Scroll:
  - Stimulus: STEP_CYCLES=4, GAP=2; buf = A..J; msg_len=10; start.
  - Response: window A..H first, then B..I after 4 cycles. At offset 5 the window is F G H I J _ _ A.
  - Wrap: after 12 steps (48 cycles) offset=0 and wrap_pulse is high exactly 1 cycle.
- Clamp and zero length:
  - msg_len=20 -> behaves as 16 (P=18, wrap every 72 cycles at STEP_CYCLES=4).
  - msg_len=0 with start from IDLE -> busy stays 0.
- Control collisions:
  - start and stop on the same edge -> IDLE, blank.
  - start during SCROLL at offset 7 -> offset 0 on the next edge, divider restarted.
- Live write: during SCROLL, write Z to buf[1] while it is visible -> its slot shows Z within 2 edges; no disturbance to offset.
